// File: rtl/hamming_link_pkg.sv
// Shared types and widths for the Hamming(7,4) link arbiter.
package hamming_link_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RX, RESP} hl_state_t;

  localparam int MSG_W   = 4;
  localparam int CODE_W  = 7;
  localparam int POS_W   = 3;
  localparam int POS_MAX = 6;

  // A position beyond the last codeword bit cannot be injected.
  function automatic logic pos_bad(input logic [POS_W-1:0] p);
    return p > POS_W'(POS_MAX);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);
  localparam logic [IW:0] NV = (IW+1)'(N);

  logic [IW:0] sum;
  logic        found;

  // Walk the requesters starting at ptr, wrapping modulo N; the first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= NV) sum = sum - NV;
      if (!found && req[sum[IW-1:0]]) begin
        found             = 1'b1;
        gnt[sum[IW-1:0]]  = 1'b1;
        idx               = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/hamming_link_arbiter.sv
// Round-robin scheduler sharing one Hamming(7,4) link among N_REQ requesters.
// One transaction at a time: grant, launch on link_ready, wait for a fresh
// rx_valid rising edge (or time out), then return the result to the winner.
module hamming_link_arbiter
  import hamming_link_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [MSG_W*N_REQ-1:0]   req_msg,
  input  logic [N_REQ-1:0]         req_inj,
  input  logic [POS_W*N_REQ-1:0]   req_pos1,
  input  logic [POS_W*N_REQ-1:0]   req_pos2,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         resp_valid,
  output logic [CODE_W-1:0]        resp_code,
  output logic                     resp_err,
  output logic                     resp_timeout,
  output logic                     resp_cfg_err,
  input  logic                     link_ready,
  output logic [MSG_W-1:0]         link_message,
  output logic                     link_error_inject,
  output logic [POS_W-1:0]         link_error_pos1,
  output logic [POS_W-1:0]         link_error_pos2,
  input  logic                     link_rx_valid,
  input  logic [CODE_W-1:0]        link_rx,
  input  logic                     link_error_det,
  output logic                     busy,
  output logic [CNT_W-1:0]         txn_count,
  output logic [CNT_W-1:0]         err_count
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  hl_state_t         state, state_d;
  logic [IW-1:0]     ptr, win, arb_idx;
  logic [N_REQ-1:0]  arb_gnt;
  logic [TW-1:0]     timer;
  logic              take, rx_edge, tmo, active, rx_valid_q;

  logic [MSG_W-1:0]  msg_a  [N_REQ];
  logic [POS_W-1:0]  pos1_a [N_REQ];
  logic [POS_W-1:0]  pos2_a [N_REQ];

  logic [MSG_W-1:0]  msg_q;
  logic [POS_W-1:0]  pos1_q, pos2_q;
  logic              inj_q, cfg_q;
  logic [CODE_W-1:0] code_q;
  logic              err_q, to_q;

  for (genvar g = 0; g < N_REQ; g++) begin : g_slot
    assign msg_a[g]  = req_msg[g*MSG_W +: MSG_W];
    assign pos1_a[g] = req_pos1[g*POS_W +: POS_W];
    assign pos2_a[g] = req_pos2[g*POS_W +: POS_W];
  end

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign take    = (state == IDLE) && |req;
  assign active  = (state == ISSUE) || (state == WAIT_RX);
  // Only a fresh edge counts, so an rx_valid still high from launch is ignored.
  assign rx_edge = link_rx_valid & ~rx_valid_q;
  // Timer is 0 in the first ISSUE cycle; this fires so RESP lands TIMEOUT cycles in.
  assign tmo     = timer == TW'(TIMEOUT - 1);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic; a timeout in ISSUE beats a late launch, an rx edge beats a timeout.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (take) state_d = ISSUE;
      ISSUE:   if (tmo) state_d = RESP;
               else if (link_ready) state_d = WAIT_RX;
      WAIT_RX: if (rx_edge || tmo) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; grant is suppressed while reset is held.
  always_comb begin
    gnt        = '0;
    resp_valid = '0;
    if (!reset && state == IDLE) gnt = arb_gnt;
    if (state == RESP) resp_valid[win] = 1'b1;
  end

  assign busy              = state != IDLE;
  assign link_message      = msg_q;
  assign link_error_inject = inj_q;
  assign link_error_pos1   = pos1_q;
  assign link_error_pos2   = pos2_q;
  assign resp_code         = code_q;
  assign resp_err          = err_q;
  assign resp_timeout      = to_q;
  assign resp_cfg_err      = cfg_q;

  // Holding regs and rr pointer load only at grant, keeping the link inputs stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr    <= '0;
      win    <= '0;
      msg_q  <= '0;
      pos1_q <= '0;
      pos2_q <= '0;
      inj_q  <= 1'b0;
      cfg_q  <= 1'b0;
    end else if (take) begin
      win    <= arb_idx;
      ptr    <= (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
      msg_q  <= msg_a[arb_idx];
      pos1_q <= pos1_a[arb_idx];
      pos2_q <= pos2_a[arb_idx];
      cfg_q  <= pos_bad(pos1_a[arb_idx]) | pos_bad(pos2_a[arb_idx]);
      inj_q  <= req_inj[arb_idx] & ~(pos_bad(pos1_a[arb_idx]) | pos_bad(pos2_a[arb_idx]));
    end
  end

  // Transaction timer, rx_valid history and response capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer      <= '0;
      rx_valid_q <= 1'b0;
      code_q     <= '0;
      err_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      rx_valid_q <= link_rx_valid;
      if (take)        timer <= '0;
      else if (active) timer <= timer + 1'b1;
      if (state == WAIT_RX && rx_edge) begin
        code_q <= link_rx;
        err_q  <= link_error_det;
        to_q   <= 1'b0;
      end else if (active && tmo) begin
        code_q <= '0;
        err_q  <= 1'b0;
        to_q   <= 1'b1;
      end
    end
  end

  // Saturating statistics, bumped once per response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txn_count <= '0;
      err_count <= '0;
    end else if (state == RESP) begin
      if (txn_count != '1)          txn_count <= txn_count + 1'b1;
      if (err_q && err_count != '1) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_link_arbiter.sv
// Bench for hamming_link_arbiter: directed table, multi-cycle corner cases,
// and randomized transactions against a transaction-level reference model.
module tb_hamming_link_arbiter;

  localparam int N   = 4;
  localparam int TMO = 32;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [4*N-1:0] req_msg;
  logic [N-1:0]   req_inj;
  logic [3*N-1:0] req_pos1, req_pos2;
  logic [N-1:0]   gnt, resp_valid;
  logic [6:0]     resp_code;
  logic           resp_err, resp_timeout, resp_cfg_err;
  logic           link_ready;
  logic [3:0]     link_message;
  logic           link_error_inject;
  logic [2:0]     link_error_pos1, link_error_pos2;
  logic           link_rx_valid;
  logic [6:0]     link_rx;
  logic           link_error_det;
  logic           busy;
  logic [CW-1:0]  txn_count, err_count;

  logic [3:0] s_msg [N];
  logic       s_inj [N];
  logic [2:0] s_p1  [N];
  logic [2:0] s_p2  [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_msg[g*4 +: 4]  = s_msg[g];
    assign req_inj[g]         = s_inj[g];
    assign req_pos1[g*3 +: 3] = s_p1[g];
    assign req_pos2[g*3 +: 3] = s_p2[g];
  end

  always #5 clk = ~clk;

  hamming_link_arbiter #(.N_REQ(N), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk               (clk),
    .reset             (reset),
    .req               (req),
    .req_msg           (req_msg),
    .req_inj           (req_inj),
    .req_pos1          (req_pos1),
    .req_pos2          (req_pos2),
    .gnt               (gnt),
    .resp_valid        (resp_valid),
    .resp_code         (resp_code),
    .resp_err          (resp_err),
    .resp_timeout      (resp_timeout),
    .resp_cfg_err      (resp_cfg_err),
    .link_ready        (link_ready),
    .link_message      (link_message),
    .link_error_inject (link_error_inject),
    .link_error_pos1   (link_error_pos1),
    .link_error_pos2   (link_error_pos2),
    .link_rx_valid     (link_rx_valid),
    .link_rx           (link_rx),
    .link_error_det    (link_error_det),
    .busy              (busy),
    .txn_count         (txn_count),
    .err_count         (err_count)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int m_ptr = 0;
  int m_txn = 0;
  int m_err = 0;

  typedef struct {
    logic [N-1:0] mask;
    int           slot;
    logic [3:0]   msg;
    bit           inj;
    logic [2:0]   p1;
    logic [2:0]   p2;
    bit           cfg;
    bit           linj;
    bit           err;
  } vec_t;

  vec_t tbl [6];

  // Hamming(7,4): bit0=p1, bit1=p2, bit2=d0, bit3=p4, bit4..6=d1..d3.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One full transaction; entered and left at a negedge in IDLE.
  task automatic txn(input logic [N-1:0] mask, input int rdy, input int lat,
                     input bit no_rx, input bit stale, input bit keep,
                     output bit o_cfg, output bit o_err, output bit o_linj);
    int         w, rise, exp_cyc, cyc;
    logic [N-1:0] oh;
    logic [3:0] em;
    bit         ecfg, einj, edet, got;
    logic [6:0] erx;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (w < 0 && mask[c]) w = c;
    end
    oh = '0;
    oh[w] = 1'b1;
    em   = s_msg[w];
    ecfg = (s_p1[w] == 3'd7) || (s_p2[w] == 3'd7);
    einj = s_inj[w] && !ecfg;
    erx  = enc(em);
    if (einj) begin
      erx[s_p1[w]] = ~erx[s_p1[w]];
      erx[s_p2[w]] = ~erx[s_p2[w]];
    end
    edet    = einj;
    rise    = rdy + 1 + lat;
    exp_cyc = no_rx ? TMO : rise + 1;

    req = mask;
    #1;
    chk("gnt", 32'(gnt), 32'(oh));
    @(posedge clk);
    #1;
    if (!keep) req = '0;
    m_ptr = (w + 1) % N;
    got = 1'b0;
    cyc = 0;
    while (cyc < TMO + 8 && !got) begin
      @(negedge clk);
      if (resp_valid != '0) begin
        got = 1'b1;
      end else begin
        chk("gnt_in_txn", 32'(gnt), 32'(0));
        chk("busy", 32'(busy), 32'(1));
        chk("link_msg", 32'(link_message), 32'(em));
        chk("link_inj", 32'(link_error_inject), 32'(einj));
        if (cyc == 0) chk("link_pos", 32'({link_error_pos1, link_error_pos2}), 32'({s_p1[w], s_p2[w]}));
        link_ready = (cyc >= rdy);
        if (!no_rx && cyc == rise) begin
          link_rx_valid = 1'b1; link_rx = erx; link_error_det = edet;
        end else if (stale && cyc <= rdy + 1) begin
          link_rx_valid = 1'b1; link_rx = ~erx; link_error_det = ~edet;
        end else begin
          link_rx_valid = 1'b0; link_rx = 7'($urandom); link_error_det = 1'($urandom);
        end
        cyc++;
      end
    end
    o_cfg = 1'b0; o_err = 1'b0; o_linj = 1'b0;
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL resp_seen: got no resp_valid within %0d cycles", TMO + 8);
    end else begin
      chk("resp_cycle", 32'(cyc), 32'(exp_cyc));
      chk("resp_valid", 32'(resp_valid), 32'(oh));
      chk("resp_code", 32'(resp_code), no_rx ? 32'(0) : 32'(erx));
      chk("resp_err", 32'(resp_err), no_rx ? 32'(0) : 32'(edet));
      chk("resp_timeout", 32'(resp_timeout), 32'(no_rx));
      chk("resp_cfg_err", 32'(resp_cfg_err), 32'(ecfg));
      o_cfg = resp_cfg_err; o_err = resp_err; o_linj = link_error_inject;
    end
    link_rx_valid = 1'b0;
    link_ready    = 1'b1;
    if (m_txn < SAT) m_txn++;
    if (!no_rx && edet && m_err < SAT) m_err++;
    @(negedge clk);
    chk("resp_after", 32'(resp_valid), 32'(0));
    chk("busy_after", 32'(busy), 32'(0));
    chk("txn_count", 32'(txn_count), 32'(m_txn));
    chk("err_count", 32'(err_count), 32'(m_err));
    chk("link_hold_idle", 32'(link_message), 32'(em));
  endtask

  task automatic set_slot(input int s, input logic [3:0] m, input bit i, input logic [2:0] a, input logic [2:0] b);
    s_msg[s] = m; s_inj[s] = i; s_p1[s] = a; s_p2[s] = b;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit oc, oe, ol;
    tbl[0] = '{4'b0001, 0, 4'hA, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{4'b0100, 2, 4'h6, 1'b1, 3'd5, 3'd5, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{4'b0010, 1, 4'h3, 1'b1, 3'd7, 3'd2, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{4'b1000, 3, 4'hF, 1'b1, 3'd1, 3'd4, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{4'b0001, 0, 4'h0, 1'b1, 3'd2, 3'd7, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{4'b0010, 1, 4'h9, 1'b0, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0};

    reset = 1'b1; req = '1; link_ready = 1'b1; link_rx_valid = 1'b0;
    link_rx = '0; link_error_det = 1'b0;
    for (int s = 0; s < N; s++) set_slot(s, 4'(s + 1), 1'b0, 3'd0, 3'd0);
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_outs_a", 32'({resp_valid, resp_code, resp_err, resp_timeout, resp_cfg_err, busy}), 32'(0));
    chk("rst_outs_b", 32'({link_message, link_error_inject, link_error_pos1, link_error_pos2, txn_count, err_count}), 32'(0));
    req = '0;
    reset = 1'b0;
    @(negedge clk);

    // All four requesting and held: strict rotation 0,1,2,3,0, no overlap.
    for (int k = 0; k < 5; k++) txn(4'b1111, 0, 1, 1'b0, 1'b0, 1'b1, oc, oe, ol);
    req = '0;

    for (int t = 0; t < 6; t++) begin
      set_slot(tbl[t].slot, tbl[t].msg, tbl[t].inj, tbl[t].p1, tbl[t].p2);
      txn(tbl[t].mask, 0, 1, 1'b0, 1'b0, 1'b0, oc, oe, ol);
      chk("tbl_cfg", 32'(oc), 32'(tbl[t].cfg));
      chk("tbl_linj", 32'(ol), 32'(tbl[t].linj));
      chk("tbl_err", 32'(oe), 32'(tbl[t].err));
    end

    // Timeout in WAIT_RX (link never answers), then in ISSUE (link never ready).
    set_slot(2, 4'h5, 1'b0, 3'd0, 3'd0);
    txn(4'b0100, 0, 0, 1'b1, 1'b0, 1'b0, oc, oe, ol);
    txn(4'b0100, 1000, 0, 1'b1, 1'b0, 1'b0, oc, oe, ol);
    txn(4'b0100, 0, 2, 1'b0, 1'b0, 1'b0, oc, oe, ol);

    // Late ready plus rx_valid already high at launch: only the later edge completes.
    set_slot(0, 4'hC, 1'b1, 3'd3, 3'd6);
    txn(4'b0001, 3, 3, 1'b0, 1'b1, 1'b0, oc, oe, ol);

    // Reset in WAIT_RX: immediate clear, lost response, pointer back to 0.
    set_slot(1, 4'hB, 1'b1, 3'd1, 3'd2);
    req = 4'b0010;
    #1;
    chk("rstw_gnt", 32'(gnt), 32'(4'b0010));
    @(posedge clk);
    #1 req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstw_outs_a", 32'({gnt, resp_valid, resp_code, resp_err, resp_timeout, resp_cfg_err, busy}), 32'(0));
    chk("rstw_outs_b", 32'({link_message, link_error_inject, link_error_pos1, link_error_pos2, txn_count, err_count}), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 0; m_txn = 0; m_err = 0;
    link_rx_valid = 1'b1; link_rx = 7'h55;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      link_rx_valid = 1'b0;
      chk("rstw_no_resp", 32'({resp_valid, busy}), 32'(0));
    end
    set_slot(0, 4'h7, 1'b0, 3'd0, 3'd0);
    set_slot(3, 4'h8, 1'b0, 3'd0, 3'd0);
    txn(4'b1001, 0, 1, 1'b0, 1'b0, 1'b0, oc, oe, ol);

    // Randomized traffic; counters will saturate at the 4-bit limit.
    for (int r = 0; r < 40; r++) begin
      logic [N-1:0] m;
      int rd, lt;
      bit st, nr;
      for (int s = 0; s < N; s++)
        set_slot(s, 4'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      m = 4'($urandom_range(1, 15));
      rd = $urandom_range(0, 3);
      lt = $urandom_range(0, 5);
      st = (lt >= 2) && 1'($urandom);
      nr = ($urandom_range(0, 15) == 0);
      txn(m, rd, lt, nr, st, 1'($urandom), oc, oe, ol);
      req = '0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
